// File: rtl/key_loader.sv
// Serial-to-parallel key loader: MSB-first gated bit stream in, one-cycle key_write commit out.
// Optional lock-after-first-key behaviour is enabled by defining KEY_LOADER_LOCK_EN.
module key_loader #(
  parameter int KEY_WIDTH      = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_req,
  input  logic                 sin_data,
  input  logic                 sin_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 locked,
  output logic                 key_write,
  output logic [KEY_WIDTH-1:0] key_data_in
);

  localparam int CNT_W  = $clog2(KEY_WIDTH);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, ABORT} state_t;

  state_t               state, state_nxt;
  logic [KEY_WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [IDLE_W-1:0]    idle_cnt, idle_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    idle_cnt_nxt = idle_cnt;
    case (state)
      IDLE: begin
        if (load_req) begin
          state_nxt    = locked ? ABORT : SHIFT;
          shreg_nxt    = '0;
          bit_cnt_nxt  = '0;
          idle_cnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          shreg_nxt    = {shreg[KEY_WIDTH-2:0], sin_data};
          bit_cnt_nxt  = bit_cnt + 1'b1;
          idle_cnt_nxt = '0;
          // Last bit: go straight to COMMIT, counter parked at 0 rather than wrapping.
          if (bit_cnt == CNT_W'(KEY_WIDTH - 1)) begin
            state_nxt   = COMMIT;
            bit_cnt_nxt = '0;
          end
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
          if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = ABORT;
          end
        end
      end
      COMMIT: state_nxt = IDLE;
      ABORT: begin
        state_nxt = IDLE;
        shreg_nxt = '0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      key_write   <= 1'b0;
      key_data_in <= '0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      idle_cnt    <= idle_cnt_nxt;
      busy        <= (state_nxt == SHIFT) || (state_nxt == COMMIT);
      done        <= (state_nxt == COMMIT);
      err         <= (state_nxt == ABORT);
      key_write   <= (state_nxt == COMMIT);
      key_data_in <= (state_nxt == COMMIT) ? shreg_nxt : '0;
    end
  end

`ifdef KEY_LOADER_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else if (state == COMMIT) begin
      locked <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
// Directed self-checking bench for key_loader (timeout shortened to 16 cycles).
module tb_key_loader;
  localparam int KW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 1'b0;
  logic          sin_data = 1'b0;
  logic          sin_valid = 1'b0;
  logic          busy, done, err, locked, key_write;
  logic [KW-1:0] key_data_in;

  int checks = 0;
  int errors = 0;
  int kw_count = 0;
  int leak_count = 0;
  int busy_drop = 0;
  int base = 0;

  localparam logic [KW-1:0] K1   = 128'd15884;
  localparam logic [KW-1:0] KA5  = {16{8'hA5}};
  localparam logic [KW-1:0] KONE = 128'd1;
  localparam logic [KW-1:0] KTWO = 128'd2;

  key_loader #(.KEY_WIDTH(KW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .sin_data(sin_data),
    .sin_valid(sin_valid), .busy(busy), .done(done), .err(err), .locked(locked),
    .key_write(key_write), .key_data_in(key_data_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs observed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (key_write === 1'b1) kw_count++;
    if (key_write !== 1'b1 && key_data_in !== '0) leak_count++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load_req = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_key(input logic [KW-1:0] key, input int gap, input int nbits, input int req_at);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    for (int n = 0; n < nbits; n++) begin
      sin_valid = 1'b1;
      sin_data  = key[KW-1-n];
      load_req  = (n == req_at);
      step();
      load_req = 1'b0;
      if (busy !== 1'b1) busy_drop++;
      if (n != nbits - 1) begin
        for (int g = 0; g < gap; g++) begin
          sin_valid = 1'b0;
          step();
          if (busy !== 1'b1) busy_drop++;
        end
      end
    end
    sin_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_flags", {123'd0, busy, done, err, locked, key_write}, '0);
    check("rst_data", key_data_in, '0);

    // Continuous load
    base = kw_count;
    load_key(K1, 0, KW, -1);
    check("cont_kw", key_write, 1);
    check("cont_done", done, 1);
    check("cont_data", key_data_in, K1);
    check("cont_busy_commit", busy, 1);
    check("cont_latency", kw_count - base, 1);
    step();
    check("cont_post_kw", key_write, 0);
    check("cont_post_busy", busy, 0);
    check("cont_post_data", key_data_in, '0);
    repeat (3) step();
    check("cont_kw_total", kw_count - base, 1);

    // Gapped load, one valid bit every 3 cycles
    base = kw_count; busy_drop = 0;
    load_key(K1, 2, KW, -1);
    check("gap_kw", key_write, 1);
    check("gap_data", key_data_in, K1);
    check("gap_busy", busy_drop, 0);
    repeat (2) step();
    check("gap_kw_total", kw_count - base, 1);

    // Timeout after 40 bits
    do_reset();
    base = kw_count;
    load_key(K1, 0, 40, -1);
    repeat (15) step();
    check("to_no_err_early", err, 0);
    check("to_busy_waiting", busy, 1);
    step();
    check("to_err", err, 1);
    check("to_busy_abort", busy, 0);
    check("to_kw_abort", key_write, 0);
    step();
    check("to_err_pulse", err, 0);
    check("to_busy_after", busy, 0);
    check("to_data", key_data_in, '0);
    check("to_kw_total", kw_count - base, 0);

    // Ignored inputs: sin_valid in IDLE, load_req mid-SHIFT
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sin_valid = i[0]; sin_data = ~i[1];
      step();
    end
    sin_valid = 1'b0;
    check("idle_shreg", dut.shreg, '0);
    check("idle_busy", busy, 0);
    base = kw_count;
    load_key(KA5, 0, KW, 60);
    check("midreq_kw", key_write, 1);
    check("midreq_data", key_data_in, KA5);
    step();
    check("midreq_kw_total", kw_count - base, 1);

    // Reset mid-shift
    do_reset();
    base = kw_count;
    load_key(K1, 0, 64, -1);
    rst_n = 1'b0;
    #1;
    check("rstmid_flags", {123'd0, busy, done, err, locked, key_write}, '0);
    check("rstmid_data", key_data_in, '0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("rstmid_no_kw", kw_count - base, 0);
    load_key(K1, 0, KW, -1);
    check("rstmid_reload_kw", key_write, 1);
    check("rstmid_reload_data", key_data_in, K1);
    step();

    // Lock behaviour
    do_reset();
    load_key(KONE, 0, KW, -1);
    check("lock_first_data", key_data_in, KONE);
    step();
`ifdef KEY_LOADER_LOCK_EN
    check("lock_set", locked, 1);
    base = kw_count;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("lock_err", err, 1);
    check("lock_busy", busy, 0);
    sin_valid = 1'b1;
    repeat (KW + 4) step();
    sin_valid = 1'b0;
    check("lock_no_kw", kw_count - base, 0);
    check("lock_still", locked, 1);
`else
    check("nolock_flag", locked, 0);
    base = kw_count;
    load_key(KTWO, 0, KW, -1);
    check("nolock_kw", key_write, 1);
    check("nolock_data", key_data_in, KTWO);
    step();
    check("nolock_kw_total", kw_count - base, 1);
`endif

    check("no_leak", leak_count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
